instr_fetch_unit: RTL and testbench

- Instruction-fetch stage for the RV32I core, directly upstream of the decoder and the sole driver of the instruction ROM address.
- Holds the fetch PC and reads one word per cycle from the combinational instruction ROM.
- Buffers fetched {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute: a redirect flushes the FIFO and restarts fetch at the target.

---
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit.sv | 66 ++++++
 tb/tb_instr_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, execute redirect, decode handshake.
// master = fetch unit side, slave = environment (ROM, execute, decoder).
interface instr_fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err,
    input  rom_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err,
    output rom_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, one ROM read per cycle, small {pc,instr}
// queue to decode, redirect flush with misaligned-target halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] fifo_q;
  logic   [PW-1:0]         wr_ptr, rd_ptr;
  logic   [CW-1:0]         count;
  logic   [31:0]           fetch_pc;
  logic                    halted, misalign_q;
  logic                    pop, push;

  assign pop  = (count != '0) & bus.out_ready;
  assign push = !bus.redirect_valid & !halted & ((count < CW'(FIFO_DEPTH)) | pop);

  // Redirect wins over everything: flush, realign target, record misalignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc   <= RESET_PC;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      halted     <= 1'b0;
      misalign_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      halted     <= |bus.redirect_pc[1:0];
      misalign_q <= |bus.redirect_pc[1:0];
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: fetch_pc, instr: bus.rom_data};
  end

  assign bus.rom_addr     = fetch_pc;
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = fifo_q[rd_ptr].instr;
  assign bus.out_pc       = fifo_q[rd_ptr].pc;
  assign bus.out_pc_plus4 = fifo_q[rd_ptr].pc + 32'd4;
  assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects,
// misaligned halt, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rom [64];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;
  assign bus.rom_data = rom[bus.rom_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    reset_n = 1'b1;
  endtask

  // Stream until the head shows pc; bounded so a stuck DUT still reaches the summary.
  task automatic wait_head(input logic [31:0] pc);
    int n = 0;
    while (!(bus.out_valid && bus.out_pc == pc) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_head", bus.out_pc, pc);
  endtask

  initial begin
    logic any_valid;
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h0011_0233;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_addr", bus.rom_addr, 32'h0);
    chk("rst_err", {31'b0, bus.misalign_err}, 32'd0);

    // Streaming at one per cycle
    bus.out_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("s0_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("s0_instr", bus.out_instr, 32'h0011_0233);
    for (int k = 0; k < 8; k++) begin
      chk("s_pc", bus.out_pc, 32'(4 * k));
      chk("s_pc4", bus.out_pc_plus4, 32'(4 * k + 4));
      if (k > 0) chk("s_instr", bus.out_instr, 32'hA000_0000 | k);
      tick();
    end

    // Backpressure from reset
    bus.out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("bp_addr", bus.rom_addr, 32'h08);
    chk("bp_pc", bus.out_pc, 32'h00);
    chk("bp_instr", bus.out_instr, 32'h0011_0233);
    bus.out_ready = 1'b1;
    tick(); chk("bp_pop1", bus.out_pc, 32'h04);
    tick(); chk("bp_pop2", bus.out_pc, 32'h08);
    tick(); chk("bp_pop3", bus.out_pc, 32'h0C);

    // Redirect drops a full queue
    do_reset();
    wait_head(32'h54);
    bus.out_ready = 1'b0;
    tick();
    chk("rd_head", bus.out_pc, 32'h54);
    chk("rd_fill", bus.rom_addr, 32'h5C);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hA8;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    chk("rd_bubble", {31'b0, bus.out_valid}, 32'd0);
    chk("rd_addr", bus.rom_addr, 32'hA8);
    tick();
    chk("rd_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("rd_tgt", bus.out_pc, 32'hA8);
    tick();
    chk("rd_next", bus.out_pc, 32'hAC);

    // Redirect coincident with a pop
    do_reset();
    wait_head(32'h5C);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h64;
    chk("rp_hs", {31'b0, bus.out_valid}, 32'd1);
    tick();
    bus.redirect_valid = 1'b0;
    chk("rp_bubble", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("rp_tgt", bus.out_pc, 32'h64);
    tick();
    chk("rp_next", bus.out_pc, 32'h68);

    // Misaligned redirect halts until an aligned one
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h31;
    tick();
    bus.redirect_valid = 1'b0;
    chk("ma_err", {31'b0, bus.misalign_err}, 32'd1);
    chk("ma_addr", bus.rom_addr, 32'h30);
    any_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      any_valid |= bus.out_valid;
      tick();
    end
    chk("ma_halt", {31'b0, any_valid}, 32'd0);
    chk("ma_sticky", {31'b0, bus.misalign_err}, 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("ma_clr", {31'b0, bus.misalign_err}, 32'd0);
    chk("ma_bubble", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("ma_resume", bus.out_pc, 32'h40);

    // PC wrap at top of address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk("wr_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.out_pc_plus4, 32'h0);
    chk("wr_instr", bus.out_instr, 32'hA000_003F);
    tick();
    chk("wr_wrap", bus.out_pc, 32'h0);

    // Asynchronous reset with a full queue and a sticky error
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h13;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    tick(); tick(); tick();
    chk("ar_full_addr", bus.rom_addr, 32'h28);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h33;
    tick();
    bus.redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_err", {31'b0, bus.misalign_err}, 32'd0);
    chk("ar_addr", bus.rom_addr, 32'h0);
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_pc", bus.out_pc, 32'h0);
    chk("ar_valid2", {31'b0, bus.out_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
